// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal reorder blocks: bank selector type and
// a width-generic bit-reverse helper.
package bitrev_pkg;

    localparam int unsigned REV_MAX_W = 16;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_t;

    // Reverses the low k bits of x; bits at and above k come back as zero.
    function automatic logic [REV_MAX_W-1:0] rev_bits(input logic [REV_MAX_W-1:0] x,
                                                      input int unsigned k);
        logic [REV_MAX_W-1:0] r;
        logic [REV_MAX_W-1:0] s;
        r = '0;
        s = x;
        for (int unsigned i = 0; i < REV_MAX_W; i++) begin
            if (i < k) begin
                r = {r[REV_MAX_W-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_bank_ram.sv
// Two-bank frame store: one write port, one synchronous read port whose output
// register is the block's output data register.
module bitrev_bank_ram #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [K:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [K:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1 << (K + 1)) - 1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array keeps whatever it held.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_scatter.sv
// Ping-pong frame reorder buffer: words are scattered to bit-reversed addresses
// on write and drained in natural order, turning bit-reversed frames into order.
module bitrev_scatter
    import bitrev_pkg::*;
#(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    input  logic          ready_i,
    output logic          frame_err_o
);

    localparam logic [K-1:0] CNT_LAST = {K{1'b1}};

    bank_sel_t            wr_bank_q, wr_bank_d;
    bank_sel_t            rd_bank_q, rd_bank_d;
    logic [K-1:0]         wr_cnt_q, wr_cnt_d;
    logic [K-1:0]         rd_cnt_q, rd_cnt_d;
    logic [1:0]           full_q, full_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 issue;
    logic                 wr_at_last;
    logic                 rd_at_last;
    logic [REV_MAX_W-1:0] wr_rev;
    logic [K-1:0]         wr_idx;
    logic                 unused_rev;

    assign wr_rev     = rev_bits(REV_MAX_W'(wr_cnt_q), K);
    assign wr_idx     = wr_rev[K-1:0];
    assign unused_rev = ^wr_rev;

    assign ready_o    = !full_q[wr_bank_q];
    assign accept     = valid_i && ready_o;
    assign wr_at_last = (wr_cnt_q == CNT_LAST);
    assign rd_at_last = (rd_cnt_q == CNT_LAST);
    // Refill the output register whenever it is empty or being handed off.
    assign issue      = full_q[rd_bank_q] && (!valid_q || ready_i);

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        valid_d   = valid_q;
        last_d    = last_q;
        err_d     = 1'b0;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + K'(1);
            err_d    = (last_i != wr_at_last);
            if (wr_at_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = bank_sel_t'(~wr_bank_q);
            end
        end

        // Write and read always target different banks, so the full flags
        // never collide within one cycle.
        if (issue) begin
            rd_cnt_d = rd_cnt_q + K'(1);
            valid_d  = 1'b1;
            last_d   = rd_at_last;
            if (rd_at_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = bank_sel_t'(~rd_bank_q);
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= BANK_0;
            rd_cnt_q  <= '0;
            rd_bank_q <= BANK_0;
            full_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    bitrev_bank_ram #(
        .K  (K),
        .DW (DW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (accept),
        .waddr_i ({wr_bank_q, wr_idx}),
        .wdata_i (data_i),
        .re_i    (issue),
        .raddr_i ({rd_bank_q, rd_cnt_q}),
        .rdata_o (data_o)
    );

    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_bitrev_scatter.sv
// Bench for bitrev_scatter: a K=3 and a K=10 instance checked every cycle
// against a frame-level reference model, plus directed literal expectations.
module tb_bitrev_scatter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vi [2];
    logic        li [2];
    logic        ro [2];
    logic        vo [2];
    logic        lo [2];
    logic        ri [2];
    logic        fe [2];
    logic [31:0] di [2];
    logic [31:0] dout [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: words accepted, words consumed, output occupied.
    int          W [2] = '{0, 0};
    int          C [2] = '{0, 0};
    bit          mv [2] = '{1'b0, 1'b0};
    bit          errp [2] = '{1'b0, 1'b0};
    logic [31:0] inw [2][8192];
    logic [31:0] log0 [$];
    logic [31:0] log1 [$];
    int          fe_cnt0 = 0;
    bit          stop;

    always #5 clk = ~clk;

    bitrev_scatter #(.K(3), .DW(32)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[0]), .data_i(di[0]), .last_i(li[0]),
        .ready_o(ro[0]), .valid_o(vo[0]), .data_o(dout[0]), .last_o(lo[0]),
        .ready_i(ri[0]), .frame_err_o(fe[0])
    );

    bitrev_scatter #(.K(10), .DW(32)) u_dut10 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[1]), .data_i(di[1]), .last_i(li[1]),
        .ready_o(ro[1]), .valid_o(vo[1]), .data_o(dout[1]), .last_o(lo[1]),
        .ready_i(ri[1]), .frame_err_o(fe[1])
    );

    function automatic int nof(input int d);
        return (d == 0) ? 8 : 1024;
    endfunction

    function automatic int kof(input int d);
        return (d == 0) ? 3 : 10;
    endfunction

    function automatic int rev(input int x, input int k);
        int r;
        r = 0;
        for (int i = 0; i < k; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle, then advance
    // the model by what will happen at the coming rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n, issued, pend, j, idx, src;
            bit acc, cons, iss;
            n      = nof(d);
            issued = C[d] + (mv[d] ? 1 : 0);
            pend   = W[d] / n - issued / n;
            check($sformatf("ready_o[%0d]", d), 32'(ro[d]), 32'(pend < 2));
            check($sformatf("valid_o[%0d]", d), 32'(vo[d]), 32'(mv[d]));
            check($sformatf("frame_err_o[%0d]", d), 32'(fe[d]), 32'(errp[d]));
            if (mv[d]) begin
                j   = C[d];
                idx = j % n;
                src = (j / n) * n + rev(idx, kof(d));
                check($sformatf("data_o[%0d] word %0d", d, j), dout[d], inw[d][src % 8192]);
                check($sformatf("last_o[%0d] word %0d", d, j), 32'(lo[d]), 32'(idx == n - 1));
            end
            if (d == 0 && fe[0]) fe_cnt0++;
            if (!rst_n) begin
                W[d] = 0; C[d] = 0; mv[d] = 1'b0; errp[d] = 1'b0;
            end else begin
                acc     = vi[d] && (pend < 2);
                cons    = mv[d] && ri[d];
                iss     = (pend > 0) && (!mv[d] || ri[d]);
                errp[d] = acc && (li[d] != ((W[d] % n) == n - 1));
                if (acc) begin
                    inw[d][W[d] % 8192] = di[d];
                    W[d]++;
                end
                if (cons) begin
                    if (d == 0) log0.push_back(dout[0]);
                    else        log1.push_back(dout[1]);
                    C[d]++;
                end
                if (iss)       mv[d] = 1'b1;
                else if (cons) mv[d] = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input int d, input logic [31:0] v, input logic l);
        int t;
        t = 0;
        vi[d] = 1'b1; di[d] = v; li[d] = l;
        @(negedge clk);
        while (!ro[d] && t < 10000) begin
            @(negedge clk);
            t++;
        end
        if (!ro[d]) check($sformatf("push timeout dut%0d", d), 32'(ro[d]), 32'd1);
        @(posedge clk);
        #1;
        vi[d] = 1'b0;
    endtask

    task automatic check_perm(input string name, input int base, input int offs);
        int perm [8];
        perm = '{0, 4, 2, 6, 1, 5, 3, 7};
        check({name, " count"}, 32'(log0.size() - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < log0.size())
                check($sformatf("%s word %0d", name, k), log0[base + k], 32'(perm[k] + offs));
        end
    endtask

    initial begin
        int base, cnt, fbase;
        rst_n = 1'b0;
        stop  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vi[d] = 1'b0; li[d] = 1'b0; ri[d] = 1'b0; di[d] = '0;
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset ready_o[%0d]", d), 32'(ro[d]), 32'd1);
            check($sformatf("reset valid_o[%0d]", d), 32'(vo[d]), 32'd0);
            check($sformatf("reset data_o[%0d]", d), dout[d], 32'd0);
            check($sformatf("reset frame_err_o[%0d]", d), 32'(fe[d]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Single frame, consumer always ready
        ri[0] = 1'b1;
        base  = log0.size();
        for (int w = 0; w < 8; w++) push(0, 32'(w), w == 7);
        @(negedge clk);
        check("single valid_o before issue", 32'(vo[0]), 32'd0);
        @(negedge clk);
        check("single valid_o after issue", 32'(vo[0]), 32'd1);
        check("single first data_o", dout[0], 32'd0);
        @(posedge clk);
        #1;
        idle(10);
        check_perm("single", base, 0);

        // Marker mismatch on word 5
        base  = log0.size();
        fbase = fe_cnt0;
        for (int w = 0; w < 8; w++) begin
            push(0, 32'(32 + w), (w == 5) || (w == 7));
            if (w == 5) begin
                @(negedge clk);
                check("mismatch frame_err_o pulse", 32'(fe[0]), 32'd1);
                @(posedge clk);
                #1;
            end
        end
        idle(12);
        check("mismatch pulse count", 32'(fe_cnt0 - fbase), 32'd1);
        check_perm("mismatch", base, 32);

        // Fill both banks with the consumer stalled
        ri[0] = 1'b0;
        for (int w = 0; w < 16; w++) push(0, 32'(200 + w), (w % 8) == 7);
        vi[0] = 1'b1; di[0] = 32'd216; li[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("stall ready_o low", 32'(ro[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        ri[0] = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!ro[0] && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("stall drain cycles", 32'(cnt), 32'd7);
        @(posedge clk);
        #1;
        vi[0] = 1'b0;
        for (int w = 1; w < 8; w++) push(0, 32'(216 + w), w == 7);
        idle(30);

        // Reset part-way through a frame
        for (int w = 0; w < 3; w++) push(0, 32'(900 + w), 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        base = log0.size();
        for (int w = 0; w < 8; w++) push(0, 32'(w), w == 7);
        idle(12);
        check_perm("after reset", base, 0);

        // Randomised frames on the small instance, occasional bad markers
        stop = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++)
                    for (int w = 0; w < 8; w++) begin
                        idle($urandom_range(0, 2));
                        push(0, $urandom, (w == 7) ^ ($urandom_range(0, 9) == 0));
                    end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    ri[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        ri[0] = 1'b1;
        idle(40);

        // K=10 frame 0..1023 under random output backpressure, then two random frames
        base = log1.size();
        stop = 1'b0;
        fork
            begin
                for (int w = 0; w < 1024; w++) push(1, 32'(w), w == 1023);
                for (int w = 0; w < 2048; w++) begin
                    if ($urandom_range(0, 15) == 0) idle(1);
                    push(1, $urandom, (w % 1024) == 1023);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    ri[1] = 1'($urandom_range(0, 1));
                end
            end
        join
        ri[1] = 1'b1;
        idle(2200);
        check("k10 output count", 32'(log1.size() - base), 32'd3072);
        if (log1.size() - base >= 1024) begin
            check("k10 word 0", log1[base], 32'd0);
            check("k10 word 1", log1[base + 1], 32'd512);
            check("k10 word 2", log1[base + 2], 32'd256);
            check("k10 word 3", log1[base + 3], 32'd768);
            check("k10 word 1023", log1[base + 1023], 32'd1023);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
